// File: rtl/clb_tile_cfg_loader.sv
// Per-tile config loader: checks framed stream, assembles conf_out, forwards stream.
// Optional readback port enabled by `CFG_LOADER_READBACK_EN.
module clb_tile_cfg_loader #(
  parameter int          WORD    = 32,
  parameter int          CONF_W  = 256,
  parameter logic [15:0] TILE_ID = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD-1:0]   in_data,
  output logic              fwd_valid,
  input  logic              fwd_ready,
  output logic [WORD-1:0]   fwd_data,
  output logic [CONF_W-1:0] conf_out,
  output logic              cset,
  output logic              busy,
  output logic              err_hdr,
  output logic              err_chk
`ifdef CFG_LOADER_READBACK_EN
  ,
  input  logic              rb_req,
  output logic              rb_valid,
  output logic [WORD-1:0]   rb_data
`endif
);

  localparam int NWORDS = (CONF_W + WORD - 1) / WORD;
  localparam int LW     = WORD - 24;
  localparam int NB     = $clog2(NWORDS + 1);
  localparam int CW     = (LW + 1 > NB) ? LW + 1 : NB;
  localparam int SW     = NWORDS * WORD;

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, SKIP, COMMIT, RDBK
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [WORD-1:0] sum, sum_n;
  logic [SW-1:0]   shadow;

  logic          acc, hold, rb_start;
  logic          ld_wr, set_hdr, set_chk, commit;
  logic          hdr_ok, id_ok, len_ok;
  logic [LW-1:0] hdr_len;
  logic [15:0]   hdr_id;

`ifdef CFG_LOADER_READBACK_EN
  assign rb_start = rb_req && (state == IDLE);
`else
  assign rb_start = 1'b0;
`endif

  // Stream is frozen while committing or reading back.
  assign hold      = (state == COMMIT) || (state == RDBK) || rb_start;
  assign in_ready  = fwd_ready && !hold;
  assign fwd_valid = in_valid && !hold;
  assign fwd_data  = in_data;
  assign acc       = in_valid && in_ready;
  assign busy      = (state != IDLE);

  assign hdr_ok  = (in_data[7:0] == 8'hC5);
  assign hdr_id  = in_data[23:8];
  assign hdr_len = in_data[WORD-1:24];
  assign id_ok   = (hdr_id == TILE_ID);
  assign len_ok  = (CW'(hdr_len) == CW'(NWORDS));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sum_n   = sum;
    ld_wr   = 1'b0;
    set_hdr = 1'b0;
    set_chk = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rb_start) begin
          state_n = RDBK;
          cnt_n   = '0;
        end else if (acc && hdr_ok) begin
          if (id_ok && len_ok) begin
            state_n = LOAD;
            cnt_n   = '0;
            sum_n   = '0;
          end else begin
            state_n = SKIP;
            cnt_n   = CW'(hdr_len) + CW'(1);
            set_hdr = id_ok;
          end
        end
      end
      LOAD: begin
        if (acc) begin
          ld_wr = 1'b1;
          sum_n = sum ^ in_data;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(NWORDS - 1)) state_n = CHECK;
        end
      end
      CHECK: begin
        if (acc) begin
          if (in_data == sum) begin
            state_n = COMMIT;
          end else begin
            state_n = IDLE;
            set_chk = 1'b1;
          end
        end
      end
      SKIP: begin
        if (acc) begin
          cnt_n = cnt - CW'(1);
          if (cnt_n == '0) state_n = IDLE;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      RDBK: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(NWORDS - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sum      <= '0;
      shadow   <= '0;
      conf_out <= '0;
      cset     <= 1'b0;
      err_hdr  <= 1'b0;
      err_chk  <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      sum  <= sum_n;
      cset <= commit;
      if (set_hdr) err_hdr <= 1'b1;
      if (set_chk) err_chk <= 1'b1;
      if (commit)  conf_out <= shadow[CONF_W-1:0];
      for (int k = 0; k < NWORDS; k++) begin
        if (ld_wr && cnt == CW'(k))
          shadow[k*WORD +: WORD] <= in_data;
      end
    end
  end

`ifdef CFG_LOADER_READBACK_EN
  logic [SW-1:0] padded;

  assign padded   = SW'(conf_out);
  assign rb_valid = (state == RDBK);

  always_comb begin
    rb_data = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (cnt == CW'(k)) rb_data = padded[k*WORD +: WORD];
    end
  end
`endif

endmodule

// File: tb/tb_clb_tile_cfg_loader.sv
// Directed bench for clb_tile_cfg_loader (CONF_W=80, TILE_ID=0x0012).
// Readback section is built when CFG_LOADER_READBACK_EN is defined.
module tb_clb_tile_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [31:0] fwd_data;
  logic [79:0] conf_out;
  logic        cset;
  logic        busy;
  logic        err_hdr;
  logic        err_chk;
`ifdef CFG_LOADER_READBACK_EN
  logic        rb_req;
  logic        rb_valid;
  logic [31:0] rb_data;
`endif

  int total = 0;
  int bad = 0;
  int cset_cnt = 0;

  localparam logic [79:0] CONF_A = 80'h3333_22222222_11111111;
  // xor of 11111111, 22222222 and FFFF3333
  localparam logic [31:0] SUM_A = 32'hCCCC0000;

  typedef struct {
    logic [31:0] data;
    bit          tog;
    bit          busy;
    bit          ehdr;
    bit          echk;
    logic [79:0] conf;
  } vec_t;

  vec_t tv[$];

  clb_tile_cfg_loader #(
    .WORD(32),
    .CONF_W(80),
    .TILE_ID(16'h0012)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .fwd_valid(fwd_valid),
    .fwd_ready(fwd_ready),
    .fwd_data(fwd_data),
    .conf_out(conf_out),
    .cset(cset),
    .busy(busy),
    .err_hdr(err_hdr),
    .err_chk(err_chk)
`ifdef CFG_LOADER_READBACK_EN
    ,
    .rb_req(rb_req),
    .rb_valid(rb_valid),
    .rb_data(rb_data)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cset) cset_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input bit tog);
    int n;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    forever begin
      if (tog) fwd_ready = ~fwd_ready;
      else     fwd_ready = 1'b1;
      #1;
      if (!fwd_ready) check("stall_rdy", {79'd0, in_ready}, 80'd0);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        check("send_timeout", 80'd0, 80'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("fwd_valid", {79'd0, fwd_valid}, 80'd1);
    check("fwd_data", {48'd0, fwd_data}, {48'd0, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_state(input string nm, input bit b, input bit eh,
                             input bit ec, input logic [79:0] cf);
    check({nm, "_busy"}, {79'd0, busy}, {79'd0, b});
    check({nm, "_ehdr"}, {79'd0, err_hdr}, {79'd0, eh});
    check({nm, "_echk"}, {79'd0, err_chk}, {79'd0, ec});
    check({nm, "_conf"}, conf_out, cf);
  endtask

  initial begin
    // other tile, len 3: five words skipped
    tv.push_back('{32'h030013C5, 0, 1, 0, 0, 80'd0});
    tv.push_back('{32'h11111111, 0, 1, 0, 0, 80'd0});
    tv.push_back('{32'h22222222, 0, 1, 0, 0, 80'd0});
    tv.push_back('{32'hFFFF3333, 0, 1, 0, 0, 80'd0});
    tv.push_back('{SUM_A,        0, 0, 0, 0, 80'd0});
    // no magic: dropped
    tv.push_back('{32'hDEADBE00, 0, 0, 0, 0, 80'd0});
    // own frame, bad checksum
    tv.push_back('{32'h030012C5, 0, 1, 0, 0, 80'd0});
    tv.push_back('{32'h11111111, 0, 1, 0, 0, 80'd0});
    tv.push_back('{32'h22222222, 0, 1, 0, 0, 80'd0});
    tv.push_back('{32'hFFFF3333, 0, 1, 0, 0, 80'd0});
    tv.push_back('{32'h00000000, 0, 0, 0, 1, 80'd0});
    // own id, wrong len 2: header plus three words skipped
    tv.push_back('{32'h020012C5, 0, 1, 1, 1, 80'd0});
    tv.push_back('{32'hAAAAAAAA, 0, 1, 1, 1, 80'd0});
    tv.push_back('{32'hBBBBBBBB, 0, 1, 1, 1, 80'd0});
    tv.push_back('{32'h12345678, 0, 0, 1, 1, 80'd0});
    // good frame under fwd_ready toggling, ends in COMMIT
    tv.push_back('{32'h030012C5, 1, 1, 1, 1, 80'd0});
    tv.push_back('{32'h11111111, 1, 1, 1, 1, 80'd0});
    tv.push_back('{32'h22222222, 1, 1, 1, 1, 80'd0});
    tv.push_back('{32'hFFFF3333, 1, 1, 1, 1, 80'd0});
    tv.push_back('{SUM_A,        1, 1, 1, 1, 80'd0});

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    fwd_ready = 1'b1;
`ifdef CFG_LOADER_READBACK_EN
    rb_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 80'd0);
    check("reset_cset", {79'd0, cset}, 80'd0);
    check("reset_in_ready", {79'd0, in_ready}, 80'd1);
    check("reset_fwd_valid", {79'd0, fwd_valid}, 80'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].data, tv[i].tog);
      check_state($sformatf("v%0d", i), tv[i].busy, tv[i].ehdr,
                  tv[i].echk, tv[i].conf);
    end
    fwd_ready = 1'b1;
    check("cset_before_commit", 80'(cset_cnt), 80'd0);
    @(posedge clk);
    #1;
    check("tog_conf", conf_out, CONF_A);
    check("tog_cset_hi", {79'd0, cset}, 80'd1);
    @(posedge clk);
    #1;
    check("tog_cset_lo", {79'd0, cset}, 80'd0);
    check("tog_busy", {79'd0, busy}, 80'd0);

    // clean frame after reset: exact commit timing
    pulse_rst();
    check_state("rst2", 0, 0, 0, 80'd0);
    send(32'h030012C5, 0);
    send(32'h11111111, 0);
    send(32'h22222222, 0);
    send(32'hFFFF3333, 0);
    check_state("a_pre", 1, 0, 0, 80'd0);
    send(SUM_A, 0);
    check_state("a_commit", 1, 0, 0, 80'd0);
    check("a_cset0", {79'd0, cset}, 80'd0);
    @(posedge clk);
    #1;
    check_state("a_done", 0, 0, 0, CONF_A);
    check("a_cset1", {79'd0, cset}, 80'd1);
    @(posedge clk);
    #1;
    check("a_cset2", {79'd0, cset}, 80'd0);
    check("a_cset_cnt", 80'(cset_cnt), 80'd2);

`ifdef CFG_LOADER_READBACK_EN
    begin
      logic [31:0] rbx [3];
      rbx[0] = 32'h11111111;
      rbx[1] = 32'h22222222;
      rbx[2] = 32'h00003333;
      @(negedge clk);
      rb_req = 1'b1;
      #1;
      check("rb_start_rdy", {79'd0, in_ready}, 80'd0);
      @(posedge clk);
      #1;
      rb_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rb%0d_valid", k), {79'd0, rb_valid}, 80'd1);
        check($sformatf("rb%0d_data", k), {48'd0, rb_data}, {48'd0, rbx[k]});
        check($sformatf("rb%0d_busy", k), {79'd0, busy}, 80'd1);
        check($sformatf("rb%0d_rdy", k), {79'd0, in_ready}, 80'd0);
        @(posedge clk);
        #1;
      end
      check("rb_end_valid", {79'd0, rb_valid}, 80'd0);
      check("rb_end_busy", {79'd0, busy}, 80'd0);
    end
`endif

    // reset after payload word 1: partial frame discarded
    send(32'h030012C5, 0);
    send(32'h11111111, 0);
    send(32'h22222222, 0);
    check("mid_busy", {79'd0, busy}, 80'd1);
    pulse_rst();
    check_state("mid_rst", 0, 0, 0, 80'd0);
    check("mid_cset", {79'd0, cset}, 80'd0);
    send(32'hFFFF3333, 0);
    check_state("mid_w2", 0, 0, 0, 80'd0);
    send(SUM_A, 0);
    check_state("mid_chk", 0, 0, 0, 80'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_conf", conf_out, 80'd0);
    check("mid_cset_cnt", 80'(cset_cnt), 80'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
